mips_dmem_responder: RTL and testbench

//   Data-memory responder on the pipelined MIPS core's load/store port. The core
//   is the initiator; this block latches each request and inserts WAIT_STATES

---
 rtl/mips_dmem_responder.sv | 131 +++++++++++++
 tb/tb_mips_dmem_responder.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/mips_dmem_responder.sv
// rtl/mips_dmem_responder.sv - wait-stated data-memory responder for the pipelined MIPS load/store port
// Latches one request, waits WAIT_STATES cycles, then completes it with a registered one-cycle MemReady pulse.
module mips_dmem_responder #(
   parameter int ADDR_WIDTH  = 8,
   parameter int DATA_WIDTH  = 32,
   parameter int WAIT_STATES = 2
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  MemReq,
   input  logic                  MemWrite,
   input  logic [31:0]           Addr,
   input  logic [DATA_WIDTH-1:0] WriteData,
   output logic [DATA_WIDTH-1:0] ReadData,
   output logic                  MemReady,
   output logic                  AddrError,
   output logic [15:0]           test_value
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   localparam int         DEPTH     = 2 ** ADDR_WIDTH;
   localparam logic [3:0] WAIT_LAST = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

   state_t                  state_q, state_d;
   logic [3:0]              cnt_q, cnt_d;
   logic                    we_q;
   logic [31:0]             addr_q;
   logic [DATA_WIDTH-1:0]   wdata_q;
   logic [DATA_WIDTH-1:0]   rdata_q;
   logic                    ready_q;
   logic                    err_q;
   logic [15:0]             tv_q;
   logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

   logic                    txn_we;
   logic [31:0]             txn_addr;
   logic [DATA_WIDTH-1:0]   txn_wdata;
   logic [ADDR_WIDTH-1:0]   txn_word;
   logic                    txn_err;
   logic                    enter_resp;
   logic                    commit_wr;
   logic                    commit_rd;

   // With zero wait states the response edge is the acceptance edge, so the live inputs are the transaction.
   assign txn_we    = (state_q == S_IDLE) ? MemWrite  : we_q;
   assign txn_addr  = (state_q == S_IDLE) ? Addr      : addr_q;
   assign txn_wdata = (state_q == S_IDLE) ? WriteData : wdata_q;
   assign txn_word  = txn_addr[ADDR_WIDTH+1:2];
   assign txn_err   = (txn_addr[1:0] != 2'b00) || (txn_addr[31:ADDR_WIDTH+2] != '0);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (MemReq) begin
               cnt_d   = 4'd0;
               state_d = (WAIT_STATES == 0) ? S_RESP : S_WAIT;
            end
         end
         S_WAIT: begin
            if (cnt_q == WAIT_LAST) begin
               state_d = S_RESP;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         S_RESP: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Reset on the would-be response edge cancels the commit as well as the pulse.
   assign enter_resp = !RST && (state_d == S_RESP) && (state_q != S_RESP);
   assign commit_wr  = enter_resp && txn_we && !txn_err;
   assign commit_rd  = enter_resp && !txn_we && !txn_err;

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
         we_q    <= 1'b0;
         addr_q  <= 32'd0;
         wdata_q <= '0;
         rdata_q <= '0;
         ready_q <= 1'b0;
         err_q   <= 1'b0;
         tv_q    <= 16'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if ((state_q == S_IDLE) && MemReq) begin
            we_q    <= MemWrite;
            addr_q  <= Addr;
            wdata_q <= WriteData;
         end
         ready_q <= enter_resp;
         err_q   <= enter_resp && txn_err;
         if (enter_resp && txn_err) begin
            rdata_q <= '0;
         end else if (commit_rd) begin
            rdata_q <= mem_q[txn_word];
         end
         if (commit_wr && (txn_word == '0)) begin
            tv_q <= txn_wdata[15:0];
         end
      end
   end

   // Storage is never cleared; reset only affects the control path.
   always_ff @(posedge CLK) begin
      if (commit_wr) begin
         mem_q[txn_word] <= txn_wdata;
      end
   end

   assign ReadData   = rdata_q;
   assign MemReady   = ready_q;
   assign AddrError  = err_q;
   assign test_value = tv_q;

endmodule

// File: tb/tb_mips_dmem_responder.sv
// tb/tb_mips_dmem_responder.sv - directed bench for mips_dmem_responder with 2 and 0 wait states
// Table of store/load vectors plus hand-written latch, back-to-back, and mid-transaction reset sequences.
module tb_mips_dmem_responder;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst2, req2, we2, rdy2, err2;
   logic [31:0] addr2, wd2, rd2;
   logic [15:0] tv2;
   logic        rst0, req0, we0, rdy0, err0;
   logic [31:0] addr0, wd0, rd0;
   logic [15:0] tv0;

   int errors = 0;
   int checks = 0;

   mips_dmem_responder #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .WAIT_STATES(2)) u_dut2 (
      .CLK(clk), .RST(rst2), .MemReq(req2), .MemWrite(we2), .Addr(addr2), .WriteData(wd2),
      .ReadData(rd2), .MemReady(rdy2), .AddrError(err2), .test_value(tv2)
   );

   mips_dmem_responder #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .WAIT_STATES(0)) u_dut0 (
      .CLK(clk), .RST(rst0), .MemReq(req0), .MemWrite(we0), .Addr(addr0), .WriteData(wd0),
      .ReadData(rd0), .MemReady(rdy0), .AddrError(err0), .test_value(tv0)
   );

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        exp_err;
      logic [31:0] exp_rd;
      logic [15:0] exp_tv;
   } vec_t;

   vec_t vt [12];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Called just after a negedge; returns number of negedges from acceptance to the MemReady sample.
   task automatic txn(input int sel, input logic we, input logic [31:0] a, input logic [31:0] d,
                      output int lat, output logic [31:0] rd, output logic er, output logic [15:0] tv);
      logic r, e;
      if (sel == 0) begin
         req0 = 1'b1; we0 = we; addr0 = a; wd0 = d;
      end else begin
         req2 = 1'b1; we2 = we; addr2 = a; wd2 = d;
      end
      @(posedge clk);
      #1;
      if (sel == 0) req0 = 1'b0; else req2 = 1'b0;
      lat = -1;
      rd  = '0;
      er  = 1'b0;
      for (int n = 1; n <= 40; n++) begin
         @(negedge clk);
         r = (sel == 0) ? rdy0 : rdy2;
         e = (sel == 0) ? err0 : err2;
         if (r) begin
            lat = n;
            rd  = (sel == 0) ? rd0 : rd2;
            er  = e;
            break;
         end
         check("err_without_ready", 32'(e), 32'd0);
      end
      @(negedge clk);
      r = (sel == 0) ? rdy0 : rdy2;
      check("ready_one_cycle", 32'(r), 32'd0);
      tv = (sel == 0) ? tv0 : tv2;
   endtask

   int          lat, npulse, last, seen;
   logic [31:0] rd;
   logic        er;
   logic [15:0] tv;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      vt[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0000_0000, 16'h0000};
      vt[1]  = '{1'b0, 32'h0000_0010, 32'h0000_0000, 1'b0, 32'hDEAD_BEEF, 16'h0000};
      vt[2]  = '{1'b1, 32'h0000_0000, 32'h1234_ABCD, 1'b0, 32'hDEAD_BEEF, 16'hABCD};
      vt[3]  = '{1'b1, 32'h0000_0004, 32'h5555_AAAA, 1'b0, 32'hDEAD_BEEF, 16'hABCD};
      vt[4]  = '{1'b0, 32'h0000_0002, 32'h0000_0000, 1'b1, 32'h0000_0000, 16'hABCD};
      vt[5]  = '{1'b1, 32'h0000_0400, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 16'hABCD};
      vt[6]  = '{1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, 32'h1234_ABCD, 16'hABCD};
      vt[7]  = '{1'b0, 32'h0000_0004, 32'h0000_0000, 1'b0, 32'h5555_AAAA, 16'hABCD};
      vt[8]  = '{1'b0, 32'h0000_0010, 32'h0000_0000, 1'b0, 32'hDEAD_BEEF, 16'hABCD};
      vt[9]  = '{1'b0, 32'hFFFF_FFFC, 32'h0000_0000, 1'b1, 32'h0000_0000, 16'hABCD};
      vt[10] = '{1'b1, 32'h0000_03FC, 32'hCAFE_F00D, 1'b0, 32'h0000_0000, 16'hABCD};
      vt[11] = '{1'b0, 32'h0000_03FC, 32'h0000_0000, 1'b0, 32'hCAFE_F00D, 16'hABCD};

      rst2 = 1'b1; req2 = 1'b0; we2 = 1'b0; addr2 = '0; wd2 = '0;
      rst0 = 1'b1; req0 = 1'b0; we0 = 1'b0; addr0 = '0; wd0 = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset_rd",    rd2,  32'd0);
      check("reset_ready", 32'(rdy2), 32'd0);
      check("reset_err",   32'(err2), 32'd0);
      check("reset_tv",    32'(tv2),  32'd0);
      check("reset_ready_w0", 32'(rdy0), 32'd0);
      rst2 = 1'b0;
      rst0 = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 12; i++) begin
         txn(2, vt[i].we, vt[i].addr, vt[i].wdata, lat, rd, er, tv);
         check($sformatf("vec%0d_latency", i), 32'(lat), 32'd3);
         check($sformatf("vec%0d_err", i),     32'(er),  32'(vt[i].exp_err));
         check($sformatf("vec%0d_rd", i),      rd,       vt[i].exp_rd);
         check($sformatf("vec%0d_tv", i),      32'(tv),  32'(vt[i].exp_tv));
      end

      // Inputs changed and MemReq dropped during WAIT must not affect the accepted store.
      txn(2, 1'b1, 32'h18, 32'h0BAD_F00D, lat, rd, er, tv);
      req2 = 1'b1; we2 = 1'b1; addr2 = 32'h14; wd2 = 32'h7777_1111;
      @(posedge clk);
      #1;
      req2 = 1'b0; we2 = 1'b0; addr2 = 32'h18; wd2 = 32'h0;
      lat = -1;
      for (int n = 1; n <= 20; n++) begin
         @(negedge clk);
         if (rdy2) begin
            lat = n;
            break;
         end
      end
      check("latched_latency", 32'(lat), 32'd3);
      check("latched_err", 32'(err2), 32'd0);
      @(negedge clk);
      txn(2, 1'b0, 32'h14, 32'h0, lat, rd, er, tv);
      check("latched_store_data", rd, 32'h7777_1111);
      txn(2, 1'b0, 32'h18, 32'h0, lat, rd, er, tv);
      check("latched_other_word", rd, 32'h0BAD_F00D);

      // MemReq held high: a new request is taken every WAIT_STATES+2 cycles.
      req2 = 1'b1; we2 = 1'b0; addr2 = 32'h10; wd2 = 32'h0;
      npulse = 0;
      last   = 0;
      for (int n = 1; n <= 20; n++) begin
         @(negedge clk);
         if (rdy2) begin
            if (npulse > 0) check("b2b_spacing", 32'(n - last), 32'd4);
            check("b2b_rd", rd2, 32'hDEAD_BEEF);
            npulse++;
            last = n;
         end
      end
      req2 = 1'b0;
      check("b2b_pulses", 32'(npulse), 32'd5);
      repeat (6) @(negedge clk);

      // Reset during WAIT of a store aborts it completely.
      txn(2, 1'b1, 32'h8, 32'h1111_2222, lat, rd, er, tv);
      req2 = 1'b1; we2 = 1'b1; addr2 = 32'h8; wd2 = 32'h9999_8888;
      @(posedge clk);
      #1;
      req2 = 1'b0;
      @(negedge clk);
      rst2 = 1'b1;
      @(negedge clk);
      rst2 = 1'b0;
      check("midreset_rd", rd2, 32'd0);
      check("midreset_tv", 32'(tv2), 32'd0);
      seen = 0;
      for (int n = 0; n < 8; n++) begin
         @(negedge clk);
         if (rdy2) seen++;
      end
      check("midreset_no_ready", 32'(seen), 32'd0);
      txn(2, 1'b0, 32'h8, 32'h0, lat, rd, er, tv);
      check("midreset_old_data", rd, 32'h1111_2222);
      check("midreset_load_latency", 32'(lat), 32'd3);

      // Zero wait states.
      txn(0, 1'b1, 32'h10, 32'hDEAD_BEEF, lat, rd, er, tv);
      check("w0_store_latency", 32'(lat), 32'd1);
      txn(0, 1'b0, 32'h10, 32'h0, lat, rd, er, tv);
      check("w0_load_latency", 32'(lat), 32'd1);
      check("w0_load_rd", rd, 32'hDEAD_BEEF);
      txn(0, 1'b1, 32'h0, 32'h0000_5A5A, lat, rd, er, tv);
      check("w0_tv", 32'(tv), 32'h5A5A);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
